// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous single-clock FIFO with registered occupancy flags
//
// Purpose: DEPTH x WIDTH first-in first-out buffer. Reads are registered:
// rd_data carries the popped word one cycle after the accepted rd_en cycle.
// There is no fall-through. Count and flags are computed from the next-state
// count, so they always agree with one another.
//
// Ports:
//   clk          in   clock; all state changes on its rising edge
//   rst          in   synchronous active-high reset
//   wr_data      in   WIDTH  word written on an accepted write
//   wr_en        in   write request
//   rd_en        in   read request
//   rd_data      out  WIDTH  registered read word
//   rd_valid     out  one-cycle strobe marking a newly popped word
//   full         out  count == DEPTH
//   empty        out  count == 0
//   almost_full  out  count >= AF_LEVEL
//   almost_empty out  count <= AE_LEVEL
//   count        out  log2(DEPTH)+1 bits, number of stored entries
//   overflow     out  sticky: a write was dropped because the FIFO was full
//   underflow    out  sticky: a read was dropped because the FIFO was empty

module sync_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             almost_full_q, almost_full_d;
  logic             almost_empty_q, almost_empty_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             rd_accept;
  logic             wr_accept;

  // A read frees a slot at the same edge, so a write into a full FIFO is
  // accepted whenever a read is accepted alongside it. A write never makes an
  // empty FIFO readable in the same cycle.
  always_comb begin
    rd_accept = rd_en && !empty_q;
    wr_accept = wr_en && (!full_q || rd_accept);

    wr_ptr_d = wr_accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_accept ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    empty_d        = (count_d == '0);
    full_d         = (count_d == CW'(DEPTH));
    almost_full_d  = (count_d >= CW'(AF_LEVEL));
    almost_empty_d = (count_d <= CW'(AE_LEVEL));

    overflow_d  = overflow_q  || (wr_en && !wr_accept);
    underflow_d = underflow_q || (rd_en && empty_q);
  end

  // Storage is not reset; entries are only observable after being written.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      rd_data_q      <= '0;
      rd_valid_q     <= 1'b0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      rd_valid_q     <= rd_accept;
      // The array read sees the pre-edge contents, so a simultaneous write to
      // the same slot of a full FIFO still returns the oldest word.
      if (rd_accept) begin
        rd_data_q <= mem_q[rd_ptr_q];
      end
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 16, number of entries; SHALL be a power of two, at least 4.
REQ-003 Parameter AF_LEVEL, default DEPTH-2; almost_full asserts when count >= AF_LEVEL.
REQ-004 Parameter AE_LEVEL, default 2; almost_empty asserts when count <= AE_LEVEL.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-007 wr_data  input  WIDTH  write word, captured when a write is accepted.
REQ-008 wr_en  input  1  write request, level-sampled each cycle.
REQ-009 rd_en  input  1  read request, level-sampled each cycle.
REQ-010 rd_data  output  WIDTH  registered read word.
REQ-011 rd_valid  output  1  one-cycle strobe; rd_data holds a newly popped word.
REQ-012 full, empty, almost_full, almost_empty  output  1 each  registered occupancy flags.
REQ-013 count  output  log2(DEPTH)+1  registered number of stored entries, 0..DEPTH.
REQ-014 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-015 Storage: DEPTH x WIDTH array with write and read pointers of log2(DEPTH) bits; pointers wrap from DEPTH-1 to 0.
REQ-016 A write is accepted when wr_en=1 and either full=0, or full=1 with an accepted read in the same cycle.
REQ-017 An accepted write stores wr_data at the write pointer and advances the write pointer by 1 at the same edge.
REQ-018 A read is accepted when rd_en=1 and empty=0; a write in the same cycle does not make a read acceptable while empty=1 (no fall-through).
REQ-019 An accepted read loads rd_data with the word at the read pointer at the edge, advances the read pointer, and sets rd_valid=1 for exactly that one following cycle.
REQ-020 Read latency: the word is on rd_data one cycle after the rd_en cycle.
REQ-021 rd_data holds its last value when no read is accepted; rd_valid=0 in that case.
REQ-022 count changes at each edge by +1 (write only), -1 (read only), or 0 (both accepted, or neither).
REQ-023 The flags are computed from the next count and registered, so they always agree with count:
- empty = (count==0)
- full = (count==DEPTH)
- almost_full = (count>=AF_LEVEL)
- almost_empty = (count<=AE_LEVEL)
REQ-024 wr_en=1 while full=1 with no accepted read: the write is dropped, storage and pointers are unchanged, and overflow is set to 1.
REQ-025 rd_en=1 while empty=1: the read is dropped, rd_valid=0, rd_data is unchanged, and underflow is set to 1.
REQ-026 Once set, overflow and underflow remain 1 until rst.
REQ-027 Data order is strictly first-in first-out across any number of pointer wraps.

Reset
REQ-028 While rst=1 at an edge, the block SHALL set:
- both pointers = 0 and count = 0
- empty = 1 and almost_empty = 1
- full = 0 and almost_full = 0
- rd_data = 0 and rd_valid = 0
- overflow = 0 and underflow = 0
REQ-029 Storage array contents are not reset and are never observable before being written.
REQ-030 rst has priority over wr_en and rd_en in the same cycle; reset mid-operation discards all stored entries.

Verification
REQ-031 Reset, then write 0xAA in one cycle, wait 255 idle cycles, then pulse rd_en -> next cycle rd_data=0xAA, rd_valid=1, then count=0, empty=1, no error flags.
REQ-032 Write 0x00..0x0F (DEPTH=16) -> full=1 and count=16 after the 16th write; almost_full=1 from count 14. A 17th write (0x55) -> overflow=1, count stays 16. Read 16 words -> 0x00..0x0F in order, then empty=1.
REQ-033 With full=1, assert wr_en=1 (0x77) and rd_en=1 together -> the read returns the oldest word, the write is accepted, count stays 16, overflow unchanged.
REQ-034 With empty=1, assert wr_en=1 (0x33) and rd_en=1 together -> count=1, rd_valid=0, underflow=1. The next read returns 0x33.
REQ-035 Run 40 writes interleaved with 40 reads of an incrementing pattern so both pointers wrap at least twice -> the output sequence equals the input sequence and count never exceeds DEPTH.
REQ-036 Store 5 words, assert rst for one cycle with wr_en=1 -> count=0, empty=1, flags cleared; a following read sets underflow=1 and returns no data.
